aes_decipher_round: RTL and testbench

//  One AES inverse cipher round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) as a 3-stage valid/ready pipeline.

---
 rtl/aes_dec_pkg.sv | 64 ++++++
 rtl/aes_inv_mixcolumn.sv | 19 +
 rtl/aes_decipher_round.sv | 90 +++++++++
 tb/tb_aes_decipher_round.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the AES inverse cipher round.
// Byte i of a block sits at [127-8i -: 8]; state[r][c] is byte 4c+r.
package aes_dec_pkg;

  typedef logic [127:0] block_t;

  localparam int BYTE_W = 8;
  localparam int COL_W  = 32;
  localparam int NB_ROW = 4;
  localparam int NB_COL = 4;

  function automatic int byte_msb(input int r, input int c);
    return 127 - BYTE_W * (NB_ROW * c + r);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < NB_COL; c++) begin
      for (int r = 0; r < NB_ROW; r++) begin
        o[byte_msb(r, c) -: BYTE_W] = s[byte_msb(r, (c - r + NB_COL) % NB_COL) -: BYTE_W];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_mixcolumn.sv
// InvMixColumns on one 32-bit column, [e b d 9] circulant; byte 0 at [31:24].
// Latency: combinational. Backpressure: none.
module aes_inv_mixcolumn
  import aes_dec_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_in;

  assign col_out[31:24] = gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3);
  assign col_out[23:16] = gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3);
  assign col_out[15:8]  = gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3);
  assign col_out[7:0]   = gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3);

endmodule

// File: rtl/aes_decipher_round.sv
// One AES inverse round (InvShiftRows, external InvSubBytes, AddRoundKey, InvMixColumns).
// Latency: 3 register stages. Backpressure: valid/ready, each stage advances when empty or drained.
// Option AES_DEC_LAST_ROUND_EN adds a last_round input that skips InvMixColumns.
module aes_decipher_round
  import aes_dec_pkg::*;
#(
  parameter bit KEY_LATCH = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] round_key,
`ifdef AES_DEC_LAST_ROUND_EN
  input  logic         last_round,
`endif
  output logic [127:0] isbox_in,
  input  logic [127:0] isbox_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  logic   s1_valid, s2_valid, s3_valid;
  logic   s1_adv, s2_adv, s3_adv;
  logic   in_fire;
  block_t s1, s2, s3, k1;
  block_t stage_key;
  block_t imc_out;

  assign isbox_in = inv_shift_rows(in_block);

  assign s3_adv   = !s3_valid | out_ready;
  assign s2_adv   = !s2_valid | s3_adv;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = reset_n & s1_adv;
  assign in_fire  = in_valid & in_ready;

  assign out_valid = reset_n & s3_valid;
  assign out_block = s3;

  assign stage_key = KEY_LATCH ? k1 : round_key;

  for (genvar c = 0; c < NB_COL; c++) begin : g_imc
    aes_inv_mixcolumn u_imc (
      .col_in  (s2[127-COL_W*c -: COL_W]),
      .col_out (imc_out[127-COL_W*c -: COL_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_fire;
      if (s2_adv) s2_valid <= s1_valid;
      if (s3_adv) s3_valid <= s2_valid;
    end
  end

`ifdef AES_DEC_LAST_ROUND_EN
  logic l1, l2;

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1 <= isbox_out;
      k1 <= round_key;
      l1 <= last_round;
    end
    if (s2_adv) begin
      s2 <= s1 ^ stage_key;
      l2 <= l1;
    end
    if (s3_adv) s3 <= l2 ? s2 : imc_out;
  end
`else
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1 <= isbox_out;
      k1 <= round_key;
    end
    if (s2_adv) s2 <= s1 ^ stage_key;
    if (s3_adv) s3 <= imc_out;
  end
`endif

endmodule

// File: tb/tb_aes_decipher_round.sv
// Scoreboard bench for aes_decipher_round: reference round computed on a 4x4 byte state.
// Also builds with AES_DEC_LAST_ROUND_EN defined to exercise the last-round bypass.
module tb_aes_decipher_round;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] round_key;
  logic [127:0] isbox_in;
  logic [127:0] isbox_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
`ifdef AES_DEC_LAST_ROUND_EN
  logic         last_round;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  bit tbl_ready = 1'b0;
  bit rand_bp = 1'b0;
  bit bp_done;
  logic [7:0] inv_sbox [256];
  logic [127:0] exp_q [$];

  aes_decipher_round dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .round_key (round_key),
`ifdef AES_DEC_LAST_ROUND_EN
    .last_round(last_round),
`endif
    .isbox_in  (isbox_in),
    .isbox_out (isbox_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External inverse S-box, combinational.
  always_comb begin
    isbox_out = '0;
    if (tbl_ready)
      for (int i = 0; i < 16; i++) isbox_out[127-8*i -: 8] = inv_sbox[isbox_in[127-8*i -: 8]];
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] blk, input logic [127:0] key, input bit last);
    logic [7:0] st [4][4];
    logic [7:0] ak [4][4];
    logic [7:0] coef [4];
    logic [7:0] acc;
    logic [127:0] res = '0;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = blk[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ak[r][c] = inv_sbox[st[r][(c-r+4)%4]] ^ key[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gm(coef[(k-r+4)%4], ak[k][c]);
        res[127-8*(4*c+r) -: 8] = last ? ak[r][c] : acc;
      end
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called just after a negedge; returns on the negedge following the accept.
  task automatic send(input logic [127:0] b, input logic [127:0] k, input bit l,
                      input bit use_exp, input logic [127:0] exp);
    int n = 0;
    in_valid = 1'b1;
    in_block = b;
    round_key = k;
`ifdef AES_DEC_LAST_ROUND_EN
    last_round = l;
`endif
    #1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 128'(in_ready), 128'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(use_exp ? exp : ref_round(b, k, l));
    acc_cnt++;
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    round_key = rnd128();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_latency(input string name);
    int n = 0;
    #2;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, 128'(cyc - acc_cyc), 128'd3);
  endtask

  // Monitor: pops and compares on every output transfer, checks hold stability.
  initial begin
    logic [127:0] hold_blk = '0;
    bit hold_pending = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        hold_pending = 1'b0;
        chk("out_valid_in_reset", 128'(out_valid), 128'd0);
        chk("in_ready_in_reset", 128'(in_ready), 128'd0);
      end else if (out_valid) begin
        if (hold_pending) chk("out_block_stable", out_block, hold_blk);
        hold_pending = !out_ready;
        hold_blk = out_block;
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none", out_block);
          end else begin
            chk("out_block", out_block, exp_q.pop_front());
          end
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_sbox[s] = 8'(x);
    end
    tbl_ready = 1'b1;

    reset_n = 1'b0;
    in_valid = 1'b0;
    in_block = '0;
    round_key = '0;
    out_ready = 1'b1;
`ifdef AES_DEC_LAST_ROUND_EN
    last_round = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("in_ready_after_reset", 128'(in_ready), 128'd1);
    chk("out_valid_after_reset", 128'(out_valid), 128'd0);

    // FIPS-197 C.1 inverse round 1; isbox_in does not depend on in_valid.
    in_block = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    #1;
    chk("isbox_in_shift", isbox_in, 128'h7a9f102789d5f50b2beffd9f3dca4ea7);
    @(negedge clk);
    send(128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h549932d1f08557681093ed9cbe2c974e, 1'b0,
         1'b1, 128'h54d990a16ba09ab596bbf40ea111702f);
    check_latency("latency_fips");
    drain();

`ifdef AES_DEC_LAST_ROUND_EN
    @(negedge clk);
    send(128'h6353e08c0960e104cd70b751bacad0e7, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
         1'b1, 128'h00112233445566778899aabbccddeeff);
    check_latency("latency_last_round");
    drain();
`endif

    // Streaming: 8 back-to-back blocks, 8 consecutive outputs from cycle 3.
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd128(), rnd128(), 1'b0, 1'b0, '0);
      end
    join_none
    repeat (3) @(negedge clk);
    #2;
    for (int i = 0; i < 8; i++) begin
      chk("stream_out_valid", 128'(out_valid), 128'd1);
      @(negedge clk);
      #2;
    end
    drain();

    // Backpressure: 3 accepts fill the pipe, then in_ready drops.
    @(negedge clk);
    out_ready = 1'b0;
    acc_cnt = 0;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rnd128(), rnd128(), 1'b0, 1'b0, '0);
        bp_done = 1'b1;
      end
    join_none
    repeat (5) @(negedge clk);
    #2;
    chk("bp_accepts", 128'(acc_cnt), 128'd3);
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    @(negedge clk);
    out_ready = 1'b1;
    for (int n = 0; n < 100 && !bp_done; n++) @(negedge clk);
    chk("bp_sender_done", 128'(bp_done), 128'd1);
    drain();
    chk("bp_total_accepts", 128'(acc_cnt), 128'd6);

    // Reset with two blocks in flight: nothing emitted for them.
    @(negedge clk);
    send(rnd128(), rnd128(), 1'b0, 1'b0, '0);
    send(rnd128(), rnd128(), 1'b0, 1'b0, '0);
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("in_ready_after_midreset", 128'(in_ready), 128'd1);
    for (int i = 0; i < 3; i++) begin
      chk("no_output_after_midreset", 128'(out_valid), 128'd0);
      @(negedge clk);
      #2;
    end
    send(rnd128(), rnd128(), 1'b0, 1'b0, '0);
    check_latency("latency_after_midreset");
    drain();

    // Key latch: round_key changes every cycle after accept.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      send(rnd128(), rnd128(), 1'b0, 1'b0, '0);
      repeat ($urandom_range(0, 2)) begin
        round_key = rnd128();
        @(negedge clk);
      end
    end
    drain();

    // Randomized traffic with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      bit l = 1'b0;
`ifdef AES_DEC_LAST_ROUND_EN
      l = ($urandom_range(0, 3) == 0);
`endif
      send(rnd128(), rnd128(), l, 1'b0, '0);
      repeat ($urandom_range(0, 2)) begin
        round_key = rnd128();
        @(negedge clk);
      end
    end
    rand_bp = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
